asym_ram_fifo: RTL and testbench
================================

// Module: asym_ram_fifo
// PURPOSE
// Single-clock FIFO with independent write and read data widths, built on one
// inferred RAM_16K_BLK-class array. Generalises fixed asymmetric RAM test
// configurations (e.g. 32-bit write / 16-bit read) to any power-of-two width
// ratio up to 4 in either direction. Adds pointer management, flags, fill level
// and an optional output register. Lane order: the lowest RD_WIDTH slice of a
// write word is read first (upsizing: first pushed word lands in low lane).
// PARAMETERS
// WR_WIDTH   32   write word width (8,16,32; WR_WIDTH/RD_WIDTH or inverse in {1,2,4})
// RD_WIDTH   16   read word width
// WR_DEPTH   512  capacity in write words; UNITS = WR_DEPTH*WR_WIDTH/MIN_W, power of 2
// REG_RD     0    1 = extra output register on RD (read latency 2 instead of 1)
// AF_LEVEL   4    Almost_Full when free write-word slots <= AF_LEVEL
// AE_LEVEL   4    Almost_Empty when available read words <= AE_LEVEL
// (derived) MIN_W = min(WR_WIDTH,RD_WIDTH); UA = clog2(UNITS)
// PORTS
// Clk           in   1         single clock, all logic on rising edge
// Rst           in   1         asynchronous, active-high reset
// Flush         in   1         synchronous clear of FIFO contents
// Push          in   1         write request
// WD            in   WR_WIDTH  write data
// Full          out  1         fewer than WR_WIDTH/MIN_W free units
// Almost_Full   out  1         see AF_LEVEL
// Ovf_Err       out  1         one-cycle pulse: Push while Full
// Pop           in   1         read request
// RD            out  RD_WIDTH  read data
// RD_Valid      out  1         RD holds data of an accepted pop (one-cycle pulse)
// Empty         out  1         fewer than RD_WIDTH/MIN_W stored units
// Almost_Empty  out  1         see AE_LEVEL
// Udf_Err       out  1         one-cycle pulse: Pop while Empty
// Fill_Units    out  UA+1      stored data in MIN_W units, 0..UNITS
// BEHAVIOUR
// - Reset: pointers, Fill_Units, RD, RD_Valid, Full, Almost_Full, Ovf_Err,
//   Udf_Err = 0; Empty = Almost_Empty = 1. Rst mid-pop suppresses RD_Valid.
// - Pointers wr_ptr/rd_ptr count MIN_W units, UA+1 bits (extra wrap bit);
//   wr_ptr += WR_WIDTH/MIN_W per push, rd_ptr += RD_WIDTH/MIN_W per pop,
//   modulo 2^(UA+1). Fill_Units = wr_ptr - rd_ptr (registered).
// - Acceptance uses flags as seen before the edge: push iff Push & ~Full, pop
//   iff Pop & ~Empty. Push with Pop while Full: push rejected (Ovf_Err=1), pop
//   accepted. Pop with Push while Empty: pop rejected (Udf_Err=1).
// - Rejected requests change no state other than the error pulse.
// - Flags/Fill_Units reflect post-edge state one cycle after the accepting edge.
// - Partial data (downsize write < one read word) keeps Empty=1 until a full
//   read word is present.
// - Read latency: RD/RD_Valid valid 1 cycle after accepted pop (REG_RD=0),
//   2 cycles (REG_RD=1). RD holds last value when RD_Valid=0.
// - Back-to-back pops every cycle sustain one RD word per cycle.
// - Flush: highest priority after Rst; pointers/Fill cleared next edge, concurrent
//   Push/Pop discarded without error pulses, in-flight RD_Valid (REG_RD=1)
//   still delivered.
// - Full write to a wrapped address overwrites nothing unread (guaranteed by Full).
// - Memory not cleared by Rst/Flush; no reads of unwritten locations reach RD.
// TESTING
// 1 Defaults: push 0xAAAA5555; pop x2 -> RD 0x5555 then 0xAAAA, RD_Valid 1 cycle
//   after each pop; Empty=1 after second pop.
// 2 Defaults: 512 pushes -> Full=1 after 512th, Fill_Units=1024; 513th push ->
//   Ovf_Err pulse, Fill unchanged; Almost_Full=1 from Fill_Units>=1016.
// 3 WR=16,RD=32: push 0x1111 -> Empty stays 1; push 0x2222 -> Empty=0; pop ->
//   RD=0x22221111.
// 4 Full FIFO, Push&Pop same cycle -> pop data correct, Ovf_Err=1, Fill-=2.
// 5 Pop on empty -> Udf_Err pulse, RD_Valid=0; Flush with Push at Fill=10 ->
//   Fill=0, Empty=1, no error pulse.
// 6 REG_RD=1: 3 back-to-back pops, assert Rst after 2nd -> RD=0, RD_Valid=0,
//   flags at reset values; pointer wrap verified over 3*UNITS pushes/pops.

Source files
------------

// File: rtl/asym_ram_fifo_if.sv
// Handshake and data bundle between an asym_ram_fifo and its user.
interface asym_ram_fifo_if #(
  parameter int unsigned WR_WIDTH = 32,
  parameter int unsigned RD_WIDTH = 16,
  parameter int unsigned FILL_W   = 11
);
  logic                flush;
  logic                push;
  logic [WR_WIDTH-1:0] wd;
  logic                full;
  logic                almost_full;
  logic                ovf_err;
  logic                pop;
  logic [RD_WIDTH-1:0] rd;
  logic                rd_valid;
  logic                empty;
  logic                almost_empty;
  logic                udf_err;
  logic [FILL_W-1:0]   fill_units;

  modport master (
    output flush, push, wd, pop,
    input  full, almost_full, ovf_err, rd, rd_valid, empty, almost_empty,
           udf_err, fill_units
  );

  modport slave (
    input  flush, push, wd, pop,
    output full, almost_full, ovf_err, rd, rd_valid, empty, almost_empty,
           udf_err, fill_units
  );
endinterface

// File: rtl/asym_ram_fifo.sv
// Single-clock FIFO with independent write/read widths over one unit-addressed RAM.
// Pointers count MIN_W-wide units with one extra wrap bit; lowest lane is read first.
module asym_ram_fifo #(
  parameter int unsigned WR_WIDTH = 32,
  parameter int unsigned RD_WIDTH = 16,
  parameter int unsigned WR_DEPTH = 512,
  parameter int unsigned REG_RD   = 0,
  parameter int unsigned AF_LEVEL = 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input logic            clk,
  input logic            rst,
  asym_ram_fifo_if.slave bus
);
  localparam int unsigned MIN_W = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
  localparam int unsigned WR_U  = WR_WIDTH / MIN_W;
  localparam int unsigned RD_U  = RD_WIDTH / MIN_W;
  localparam int unsigned UNITS = WR_DEPTH * WR_U;
  localparam int unsigned UA    = $clog2(UNITS);
  localparam int unsigned PW    = UA + 1;

  logic [MIN_W-1:0]    mem [UNITS];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW-1:0]       wr_ptr_nx, rd_ptr_nx, fill_nx, free_nx;
  logic                push_ok_c, pop_ok_c;
  logic                full_nx, af_nx, empty_nx, ae_nx;
  logic [RD_WIDTH-1:0] rd_word;
  logic                rd_v1;

  // Acceptance from pre-edge flags, next pointers and next-state flags.
  always_comb begin
    push_ok_c = bus.push & ~bus.full & ~bus.flush;
    pop_ok_c  = bus.pop & ~bus.empty & ~bus.flush;
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (bus.flush) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
    end else begin
      if (push_ok_c) wr_ptr_nx = wr_ptr + PW'(WR_U);
      if (pop_ok_c)  rd_ptr_nx = rd_ptr + PW'(RD_U);
    end
    fill_nx  = wr_ptr_nx - rd_ptr_nx;
    free_nx  = PW'(UNITS) - fill_nx;
    full_nx  = free_nx < PW'(WR_U);
    empty_nx = fill_nx < PW'(RD_U);
    af_nx    = (32'(free_nx) / WR_U) <= AF_LEVEL;
    ae_nx    = (32'(fill_nx) / RD_U) <= AE_LEVEL;
  end

  // Pointer, flag, level and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      bus.fill_units   <= '0;
      bus.full         <= 1'b0;
      bus.almost_full  <= 1'b0;
      bus.empty        <= 1'b1;
      bus.almost_empty <= 1'b1;
      bus.ovf_err      <= 1'b0;
      bus.udf_err      <= 1'b0;
    end else begin
      wr_ptr           <= wr_ptr_nx;
      rd_ptr           <= rd_ptr_nx;
      bus.fill_units   <= fill_nx;
      bus.full         <= full_nx;
      bus.almost_full  <= af_nx;
      bus.empty        <= empty_nx;
      bus.almost_empty <= ae_nx;
      bus.ovf_err      <= bus.push & bus.full & ~bus.flush;
      bus.udf_err      <= bus.pop & bus.empty & ~bus.flush;
    end
  end

  // RAM write: one push fills WR_U consecutive units, low lane first.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      for (int unsigned i = 0; i < WR_U; i++) begin
        mem[UA'(wr_ptr[UA-1:0] + UA'(i))] <= bus.wd[i*MIN_W +: MIN_W];
      end
    end
  end

  // RAM read: gather RD_U units into one read word on an accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_word <= '0;
      rd_v1   <= 1'b0;
    end else begin
      rd_v1 <= pop_ok_c;
      if (pop_ok_c) begin
        for (int unsigned i = 0; i < RD_U; i++) begin
          rd_word[i*MIN_W +: MIN_W] <= mem[UA'(rd_ptr[UA-1:0] + UA'(i))];
        end
      end
    end
  end

  generate
    if (REG_RD != 0) begin : g_out_reg
      // Extra output stage; flush does not cancel a word already read out.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bus.rd       <= '0;
          bus.rd_valid <= 1'b0;
        end else begin
          bus.rd_valid <= rd_v1;
          if (rd_v1) bus.rd <= rd_word;
        end
      end
    end else begin : g_out_direct
      // Read word register drives the port directly.
      assign bus.rd       = rd_word;
      assign bus.rd_valid = rd_v1;
    end
  endgenerate
endmodule

// File: tb/tb_asym_ram_fifo.sv
// Bench for asym_ram_fifo: three configurations checked every cycle against a
// byte-queue model, plus directed literal checks.
module tb_asym_ram_fifo;
  localparam int NI = 3;
  // d0: 32->16 defaults, d1: 16->32, d2: 32->8 with output register
  localparam int WRW [NI] = '{32, 16, 32};
  localparam int RDW [NI] = '{16, 32, 8};
  localparam int DEP [NI] = '{512, 512, 64};
  localparam int LAT [NI] = '{1, 1, 2};
  localparam int AFL = 4;
  localparam int AEL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d [NI];
  logic        push_d [NI];
  logic        pop_d [NI];
  logic        flush_d [NI];
  logic [31:0] wd_d [NI];

  logic [31:0] o_rd [NI];
  logic [31:0] o_fill [NI];
  logic        o_rv [NI];
  logic        o_full [NI];
  logic        o_af [NI];
  logic        o_ovf [NI];
  logic        o_empty [NI];
  logic        o_ae [NI];
  logic        o_udf [NI];

  int n_vec = 0;
  int n_bad = 0;

  asym_ram_fifo_if #(.WR_WIDTH(32), .RD_WIDTH(16), .FILL_W(11)) bus0 ();
  asym_ram_fifo_if #(.WR_WIDTH(16), .RD_WIDTH(32), .FILL_W(10)) bus1 ();
  asym_ram_fifo_if #(.WR_WIDTH(32), .RD_WIDTH(8),  .FILL_W(9))  bus2 ();

  asym_ram_fifo #(.WR_WIDTH(32), .RD_WIDTH(16), .WR_DEPTH(512), .REG_RD(0),
                  .AF_LEVEL(4), .AE_LEVEL(4))
    dut0 (.clk(clk), .rst(rst_d[0]), .bus(bus0.slave));
  asym_ram_fifo #(.WR_WIDTH(16), .RD_WIDTH(32), .WR_DEPTH(512), .REG_RD(0),
                  .AF_LEVEL(4), .AE_LEVEL(4))
    dut1 (.clk(clk), .rst(rst_d[1]), .bus(bus1.slave));
  asym_ram_fifo #(.WR_WIDTH(32), .RD_WIDTH(8), .WR_DEPTH(64), .REG_RD(1),
                  .AF_LEVEL(4), .AE_LEVEL(4))
    dut2 (.clk(clk), .rst(rst_d[2]), .bus(bus2.slave));

  assign bus0.flush = flush_d[0];
  assign bus0.push  = push_d[0];
  assign bus0.pop   = pop_d[0];
  assign bus0.wd    = wd_d[0];
  assign bus1.flush = flush_d[1];
  assign bus1.push  = push_d[1];
  assign bus1.pop   = pop_d[1];
  assign bus1.wd    = wd_d[1][15:0];
  assign bus2.flush = flush_d[2];
  assign bus2.push  = push_d[2];
  assign bus2.pop   = pop_d[2];
  assign bus2.wd    = wd_d[2];

  // Uniform view of the three output bundles.
  always_comb begin
    o_rd[0] = 32'(bus0.rd);  o_fill[0] = 32'(bus0.fill_units); o_rv[0] = bus0.rd_valid;
    o_full[0] = bus0.full;   o_af[0] = bus0.almost_full;       o_ovf[0] = bus0.ovf_err;
    o_empty[0] = bus0.empty; o_ae[0] = bus0.almost_empty;      o_udf[0] = bus0.udf_err;
    o_rd[1] = 32'(bus1.rd);  o_fill[1] = 32'(bus1.fill_units); o_rv[1] = bus1.rd_valid;
    o_full[1] = bus1.full;   o_af[1] = bus1.almost_full;       o_ovf[1] = bus1.ovf_err;
    o_empty[1] = bus1.empty; o_ae[1] = bus1.almost_empty;      o_udf[1] = bus1.udf_err;
    o_rd[2] = 32'(bus2.rd);  o_fill[2] = 32'(bus2.fill_units); o_rv[2] = bus2.rd_valid;
    o_full[2] = bus2.full;   o_af[2] = bus2.almost_full;       o_ovf[2] = bus2.ovf_err;
    o_empty[2] = bus2.empty; o_ae[2] = bus2.almost_empty;      o_udf[2] = bus2.udf_err;
  end

  // ---------------- model: a queue of stored bytes per instance ----------------
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int k, input logic [7:0] b);
    case (k)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qclear(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  function automatic int cap_b(input int k);
    return DEP[k] * WRW[k] / 8;
  endfunction
  function automatic int min_b(input int k);
    return (WRW[k] < RDW[k]) ? WRW[k] / 8 : RDW[k] / 8;
  endfunction
  function automatic logic m_full(input int k, input int c);
    return (cap_b(k) - c) < WRW[k] / 8;
  endfunction
  function automatic logic m_af(input int k, input int c);
    return ((cap_b(k) - c) / (WRW[k] / 8)) <= AFL;
  endfunction
  function automatic logic m_empty(input int k, input int c);
    return c < RDW[k] / 8;
  endfunction
  function automatic logic m_ae(input int k, input int c);
    return (c / (RDW[k] / 8)) <= AEL;
  endfunction

  logic [31:0] m_rd [NI];
  logic [31:0] m_p1d [NI];
  logic        m_rv [NI];
  logic        m_p1v [NI];
  logic        m_ovf [NI];
  logic        m_udf [NI];

  // Model step on each rising edge using the inputs held through that edge.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_d[k]) begin
        qclear(k);
        m_rd[k] = '0; m_p1d[k] = '0; m_rv[k] = 1'b0; m_p1v[k] = 1'b0;
        m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
      end else begin
        int c;
        logic f, e, pok, wok;
        logic [31:0] data;
        c = qsize(k);
        f = m_full(k, c);
        e = m_empty(k, c);
        pok = pop_d[k] & ~e & ~flush_d[k];
        wok = push_d[k] & ~f & ~flush_d[k];
        m_ovf[k] = push_d[k] & f & ~flush_d[k];
        m_udf[k] = pop_d[k] & e & ~flush_d[k];
        data = '0;
        if (pok) for (int b = 0; b < RDW[k] / 8; b++) data[8*b +: 8] = qpop(k);
        if (flush_d[k]) qclear(k);
        else if (wok) for (int b = 0; b < WRW[k] / 8; b++) qpush(k, wd_d[k][8*b +: 8]);
        if (LAT[k] == 1) begin
          m_rv[k] = pok;
          if (pok) m_rd[k] = data;
        end else begin
          m_rv[k] = m_p1v[k];
          if (m_p1v[k]) m_rd[k] = m_p1d[k];
          m_p1v[k] = pok;
          if (pok) m_p1d[k] = data;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s d%0d: got %h, want %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model (reset values while Rst is high).
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int c;
      c = qsize(k);
      if (rst_d[k]) begin
        chk("rd", k, o_rd[k], 32'h0);       chk("rd_valid", k, 32'(o_rv[k]), 32'h0);
        chk("full", k, 32'(o_full[k]), 32'h0);  chk("afull", k, 32'(o_af[k]), 32'h0);
        chk("empty", k, 32'(o_empty[k]), 32'h1); chk("aempty", k, 32'(o_ae[k]), 32'h1);
        chk("ovf", k, 32'(o_ovf[k]), 32'h0);    chk("udf", k, 32'(o_udf[k]), 32'h0);
        chk("fill", k, o_fill[k], 32'h0);
      end else begin
        chk("rd", k, o_rd[k], m_rd[k]);     chk("rd_valid", k, 32'(o_rv[k]), 32'(m_rv[k]));
        chk("full", k, 32'(o_full[k]), 32'(m_full(k, c)));
        chk("afull", k, 32'(o_af[k]), 32'(m_af(k, c)));
        chk("empty", k, 32'(o_empty[k]), 32'(m_empty(k, c)));
        chk("aempty", k, 32'(o_ae[k]), 32'(m_ae(k, c)));
        chk("ovf", k, 32'(o_ovf[k]), 32'(m_ovf[k]));
        chk("udf", k, 32'(o_udf[k]), 32'(m_udf[k]));
        chk("fill", k, o_fill[k], 32'(c / min_b(k)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_d[k] = 1'b1; push_d[k] = 1'b0; pop_d[k] = 1'b0;
      flush_d[k] = 1'b0; wd_d[k] = '0;
    end
    repeat (3) step();
    chk("lit_reset_empty", 0, 32'(o_empty[0]), 32'h1);
    chk("lit_reset_fill", 0, o_fill[0], 32'h0);
    for (int k = 0; k < NI; k++) rst_d[k] = 1'b0;
    step();

    // Downsize 32->16: low lane first.
    push_d[0] = 1'b1; wd_d[0] = 32'hAAAA5555; step();
    push_d[0] = 1'b0;
    chk("lit_t1_fill", 0, o_fill[0], 32'd2);
    pop_d[0] = 1'b1; step();
    chk("lit_t1_rd0", 0, o_rd[0], 32'h5555);
    chk("lit_t1_rv0", 0, 32'(o_rv[0]), 32'h1);
    step();
    pop_d[0] = 1'b0;
    chk("lit_t1_rd1", 0, o_rd[0], 32'hAAAA);
    chk("lit_t1_empty", 0, 32'(o_empty[0]), 32'h1);
    step();
    chk("lit_t1_hold", 0, o_rd[0], 32'hAAAA);

    // Underflow, then flush with concurrent push at Fill=10.
    pop_d[0] = 1'b1; step();
    pop_d[0] = 1'b0;
    chk("lit_t5_udf", 0, 32'(o_udf[0]), 32'h1);
    chk("lit_t5_rv", 0, 32'(o_rv[0]), 32'h0);
    for (int i = 0; i < 5; i++) begin
      push_d[0] = 1'b1; wd_d[0] = 32'h1000_0000 + 32'(i); step();
    end
    chk("lit_t5_fill10", 0, o_fill[0], 32'd10);
    flush_d[0] = 1'b1; step();
    flush_d[0] = 1'b0; push_d[0] = 1'b0;
    chk("lit_t5_flush_fill", 0, o_fill[0], 32'd0);
    chk("lit_t5_flush_empty", 0, 32'(o_empty[0]), 32'h1);
    chk("lit_t5_flush_ovf", 0, 32'(o_ovf[0]), 32'h0);

    // Fill to capacity, overflow, drain.
    for (int i = 0; i < 512; i++) begin
      push_d[0] = 1'b1; wd_d[0] = {16'(i + 32'h8000), 16'(i)}; step();
      if (i == 506) chk("lit_t2_af_off", 0, 32'(o_af[0]), 32'h0);
      if (i == 507) chk("lit_t2_af_on", 0, 32'(o_af[0]), 32'h1);
    end
    chk("lit_t2_full", 0, 32'(o_full[0]), 32'h1);
    chk("lit_t2_fill", 0, o_fill[0], 32'd1024);
    step();
    push_d[0] = 1'b0;
    chk("lit_t2_ovf", 0, 32'(o_ovf[0]), 32'h1);
    chk("lit_t2_fill_hold", 0, o_fill[0], 32'd1024);
    pop_d[0] = 1'b1; step();
    chk("lit_t2_first", 0, o_rd[0], 32'h0000);
    step();
    chk("lit_t2_second", 0, o_rd[0], 32'h8000);
    repeat (1022) step();
    pop_d[0] = 1'b0; step();
    chk("lit_t2_drained", 0, 32'(o_empty[0]), 32'h1);

    // Upsize 16->32: partial word keeps Empty.
    push_d[1] = 1'b1; wd_d[1] = 32'h1111; step();
    chk("lit_t3_partial_empty", 1, 32'(o_empty[1]), 32'h1);
    wd_d[1] = 32'h2222; step();
    push_d[1] = 1'b0;
    chk("lit_t3_empty", 1, 32'(o_empty[1]), 32'h0);
    pop_d[1] = 1'b1; step();
    pop_d[1] = 1'b0;
    chk("lit_t3_rd", 1, o_rd[1], 32'h22221111);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 512; i++) begin
      push_d[1] = 1'b1; wd_d[1] = 32'(i); step();
    end
    chk("lit_t4_full", 1, 32'(o_full[1]), 32'h1);
    pop_d[1] = 1'b1; step();
    push_d[1] = 1'b0;
    chk("lit_t4_ovf", 1, 32'(o_ovf[1]), 32'h1);
    chk("lit_t4_rd", 1, o_rd[1], 32'h0001_0000);
    chk("lit_t4_fill", 1, o_fill[1], 32'd510);
    repeat (255) step();
    pop_d[1] = 1'b0; step();
    chk("lit_t4_drained", 1, o_fill[1], 32'd0);

    // Output register: reset in the middle of back-to-back pops.
    push_d[2] = 1'b1; wd_d[2] = 32'h44332211; step();
    push_d[2] = 1'b0; pop_d[2] = 1'b1; step();
    chk("lit_t6_lat", 2, 32'(o_rv[2]), 32'h0);
    step();
    chk("lit_t6_rd0", 2, o_rd[2], 32'h11);
    chk("lit_t6_rv0", 2, 32'(o_rv[2]), 32'h1);
    rst_d[2] = 1'b1; #1;
    chk("lit_t6_rst_rd", 2, o_rd[2], 32'h0);
    chk("lit_t6_rst_rv", 2, 32'(o_rv[2]), 32'h0);
    chk("lit_t6_rst_empty", 2, 32'(o_empty[2]), 32'h1);
    step();
    rst_d[2] = 1'b0; pop_d[2] = 1'b0; step();

    // Pointer wrap: stream over three times the unit capacity.
    for (int i = 0; i < 800; i++) begin
      push_d[2] = 1'b1; wd_d[2] = $urandom; pop_d[2] = (i >= 4); step();
    end
    push_d[2] = 1'b0;
    repeat (300) step();
    pop_d[2] = 1'b0; step();
    chk("lit_t6_wrap_empty", 2, o_fill[2], 32'd0);

    // Flush does not cancel a word already in the output pipeline.
    push_d[2] = 1'b1; wd_d[2] = 32'hDDCCBBAA; step();
    push_d[2] = 1'b0; pop_d[2] = 1'b1; step();
    pop_d[2] = 1'b0; flush_d[2] = 1'b1; step();
    flush_d[2] = 1'b0;
    chk("lit_flush_inflight_rv", 2, 32'(o_rv[2]), 32'h1);
    chk("lit_flush_inflight_rd", 2, o_rd[2], 32'hAA);
    chk("lit_flush_fill", 2, o_fill[2], 32'd0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
